// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO control slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fifo_pkg;

    // Coarse occupancy state; full/empty flags decode straight from it.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_status_t;

    // Number of storage words addressed by an awidth-bit RAM pointer.
    function automatic int fifo_depth(input int awidth);
        return 1 << awidth;
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/status bundle between a FIFO user and the FIFO control stage.
// Latency: wires only, no storage.
// Backpressure: requests are qualified by the ctrl's full_o/empty_o.
interface fifo_ctrl_if #(
    parameter int AWIDTH = 3
);
    logic              wr_req_i;
    logic              rd_req_i;
    logic [AWIDTH-1:0] wr_pntr_o;
    logic [AWIDTH-1:0] rd_pntr_o;
    logic              full_o;
    logic              empty_o;
    logic [AWIDTH:0]   usedw_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic              overflow_o;
    logic              underflow_o;

    // Requester side (FIFO user / testbench).
    modport master (
        output wr_req_i, rd_req_i,
        input  wr_pntr_o, rd_pntr_o, full_o, empty_o, usedw_o,
        input  almost_full_o, almost_empty_o, overflow_o, underflow_o
    );

    // Control stage side.
    modport slave (
        input  wr_req_i, rd_req_i,
        output wr_pntr_o, rd_pntr_o, full_o, empty_o, usedw_o,
        output almost_full_o, almost_empty_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_pntr.sv
// Wrap-around pointer counter; MSB acts as the lap bit for full/empty disambiguation.
// Latency: 1 cycle from inc_en to updated count.
// Backpressure: none; caller gates inc_en with its accept qualifier.
module fifo_pntr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         aclr_i,
    input  logic         inc_en,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;

    // Advance by one per accepted access, wrapping naturally modulo 2**W.
    always_ff @(posedge clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            cnt_q <= '0;
        end else if (inc_en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO control: pointers, occupancy, status and sticky error flags for ram_memory.
// Latency: all outputs registered; an accepted request shows on the outputs after one edge.
// Backpressure: writes ignored while full_o, reads ignored while empty_o (same gating as the RAM).
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AWIDTH             = 3,
    parameter int ALMOST_FULL_VALUE  = 6,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input  logic        clk_i,
    input  logic        aclr_i,
    fifo_ctrl_if.slave  bus
);
    localparam int              DEPTH   = fifo_depth(AWIDTH);
    localparam logic [AWIDTH:0] DEPTH_W = DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0] AF_W    = ALMOST_FULL_VALUE[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_W    = ALMOST_EMPTY_VALUE[AWIDTH:0];
    localparam logic [AWIDTH:0] ONE_W   = (AWIDTH + 1)'(1);

    if (AWIDTH < 1) begin : g_aw_chk
        $error("fifo_ctrl: AWIDTH must be at least 1");
    end
    if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH) begin : g_af_chk
        $error("fifo_ctrl: ALMOST_FULL_VALUE must lie in 1..DEPTH");
    end
    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH) begin : g_ae_chk
        $error("fifo_ctrl: ALMOST_EMPTY_VALUE must lie in 1..DEPTH");
    end

    fifo_status_t    state_q, state_nxt;
    logic [AWIDTH:0] usedw_q, usedw_nxt;
    logic [AWIDTH:0] wr_ptr, rd_ptr;
    logic            full_w, empty_w, wr_acc, rd_acc;
    logic            almost_full_q, almost_empty_q;
    logic            overflow_q, underflow_q;

    // Flags decode from the registered state, so accepts never depend combinationally on requests' effects.
    assign full_w  = (state_q == ST_FULL);
    assign empty_w = (state_q == ST_EMPTY);
    assign wr_acc  = bus.wr_req_i & ~full_w;
    assign rd_acc  = bus.rd_req_i & ~empty_w;

    fifo_pntr #(.W(AWIDTH + 1)) u_wr_pntr (
        .clk_i  (clk_i),
        .aclr_i (aclr_i),
        .inc_en (wr_acc),
        .cnt    (wr_ptr)
    );

    fifo_pntr #(.W(AWIDTH + 1)) u_rd_pntr (
        .clk_i  (clk_i),
        .aclr_i (aclr_i),
        .inc_en (rd_acc),
        .cnt    (rd_ptr)
    );

    // Next occupancy: a simultaneous accepted read and write cancel out.
    always_comb begin
        usedw_nxt = usedw_q;
        if (wr_acc && !rd_acc) begin
            usedw_nxt = usedw_q + ONE_W;
        end else if (rd_acc && !wr_acc) begin
            usedw_nxt = usedw_q - ONE_W;
        end
    end

    // Next status state from the accept qualifiers and the next occupancy.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_acc) begin
                    state_nxt = (usedw_nxt == DEPTH_W) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (usedw_nxt == DEPTH_W) begin
                    state_nxt = ST_FULL;
                end else if (usedw_nxt == '0) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (rd_acc) begin
                    state_nxt = ST_PARTIAL;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Status register.
    always_ff @(posedge clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Occupancy and thresholds, both from the next count so the flags align with usedw_o.
    always_ff @(posedge clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            usedw_q        <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            usedw_q        <= usedw_nxt;
            almost_full_q  <= (usedw_nxt >= AF_W);
            almost_empty_q <= (usedw_nxt < AE_W);
        end
    end

    // Sticky error flags: a rejected request is remembered until reset.
    always_ff @(posedge clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (bus.wr_req_i & full_w);
            underflow_q <= underflow_q | (bus.rd_req_i & empty_w);
        end
    end

    assign bus.wr_pntr_o      = wr_ptr[AWIDTH-1:0];
    assign bus.rd_pntr_o      = rd_ptr[AWIDTH-1:0];
    assign bus.full_o         = full_w;
    assign bus.empty_o        = empty_w;
    assign bus.usedw_o        = usedw_q;
    assign bus.almost_full_o  = almost_full_q;
    assign bus.almost_empty_o = almost_empty_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.underflow_o    = underflow_q;
endmodule
